// File: rtl/ddr3_buf_regs_pkg.sv
// ddr3_regs_pkg: register map and ERR bit layout shared by the DDR3 buffer CSR block
package ddr3_regs_pkg;
    localparam logic [7:0] OFFSET_BASE     = 8'h00;
    localparam logic [7:0] CTRL_BASE       = 8'h10;
    localparam logic [7:0] FULL_ADDR       = 8'h20;
    localparam logic [7:0] ERR_ADDR        = 8'h21;
    localparam logic [7:0] RDPTR_ADDR      = 8'h22;
    localparam logic [7:0] TEST_ADDR_ADDR  = 8'h23;
    localparam logic [7:0] TEST_WDATA_ADDR = 8'h24;
    localparam logic [7:0] TEST_CMD_ADDR   = 8'h25;
    localparam int         UDF_BIT         = 16;
endpackage

// File: rtl/ddr3_buf_regs_if.sv
// ddr3_buf_regs_if: CSR bus, reader handshake and test-write handshake of the buffer CSR block
interface ddr3_buf_regs_if #(
    parameter int NUM_BUF = 2,
    parameter int ADDR_W  = 26,
    parameter int DATA_W  = 32
);
    logic                      csr_read;
    logic                      csr_write;
    logic [7:0]                csr_addr;
    logic [DATA_W-1:0]         csr_wr_data;
    logic [DATA_W-1:0]         csr_rd_data;
    logic                      csr_rd_valid;
    logic [NUM_BUF*ADDR_W-1:0] buf_offset;
    logic [NUM_BUF-1:0]        buf_full;
    logic [3:0]                rd_buf_idx;
    logic                      rd_buf_ready;
    logic                      rd_buf_done;
    logic [ADDR_W-1:0]         test_addr;
    logic [DATA_W-1:0]         test_wr_data;
    logic                      test_wr_req;
    logic                      test_wr_ack;
    logic                      err_any;
    modport master (
        output csr_read, csr_write, csr_addr, csr_wr_data, rd_buf_done, test_wr_ack,
        input  csr_rd_data, csr_rd_valid, buf_offset, buf_full, rd_buf_idx, rd_buf_ready,
               test_addr, test_wr_data, test_wr_req, err_any
    );
    modport slave (
        input  csr_read, csr_write, csr_addr, csr_wr_data, rd_buf_done, test_wr_ack,
        output csr_rd_data, csr_rd_valid, buf_offset, buf_full, rd_buf_idx, rd_buf_ready,
               test_addr, test_wr_data, test_wr_req, err_any
    );
endinterface

// File: rtl/ddr3_buf_regs_slot.sv
// ddr3_buf_slot: one buffer descriptor - offset, full flag and sticky overflow bit
module ddr3_buf_slot #(
    parameter int ADDR_W = 26
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_offset,
    input  logic              set,
    input  logic              clr,
    input  logic              err_clr,
    output logic [ADDR_W-1:0] offset,
    output logic              full,
    output logic              ovf
);
    // clear is applied before set, so a release and refill in one cycle is not an overflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            offset <= '0;
            full   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            if (wr_en) offset <= wr_offset;
            full <= set | (full & ~clr);
            ovf  <= (set & full & ~clr) | (ovf & ~err_clr);
        end
    end
endmodule

// File: rtl/ddr3_buf_regs.sv
// ddr3_buf_regs: CSR block for DDR3 frame-buffer descriptors, round-robin reader pointer and test write
module ddr3_buf_regs
    import ddr3_regs_pkg::*;
#(
    parameter int NUM_BUF = 2,
    parameter int ADDR_W  = 26,
    parameter int DATA_W  = 32
) (
    input logic              clk,
    input logic              reset,
    ddr3_buf_regs_if.slave   bus
);
    logic [NUM_BUF-1:0][ADDR_W-1:0] offset;
    logic [NUM_BUF-1:0]             full;
    logic [NUM_BUF-1:0]             ovf;
    logic [15:0]                    full_pad;
    logic                           rel;
    logic                           udf;
    logic                           err_wr;
    logic [DATA_W-1:0]              err_val;
    logic [DATA_W-1:0]              rd_mux;

    assign err_wr           = bus.csr_write && bus.csr_addr == ERR_ADDR;
    assign full_pad         = 16'(full);
    assign bus.rd_buf_ready = full_pad[bus.rd_buf_idx];
    assign rel              = bus.rd_buf_done && bus.rd_buf_ready;
    assign bus.buf_offset   = offset;
    assign bus.buf_full     = full;
    assign bus.err_any      = |ovf || udf;

    genvar i;
    generate
        for (i = 0; i < NUM_BUF; i++) begin : g_slot
            ddr3_buf_slot #(.ADDR_W(ADDR_W)) u_slot (
                .clk      (clk),
                .reset    (reset),
                .wr_en    (bus.csr_write && bus.csr_addr == OFFSET_BASE + 8'(i)),
                .wr_offset(bus.csr_wr_data[ADDR_W-1:0]),
                .set      (bus.csr_write && bus.csr_addr == CTRL_BASE + 8'(i) && bus.csr_wr_data[0]),
                .clr      (rel && bus.rd_buf_idx == 4'(i)),
                .err_clr  (err_wr && bus.csr_wr_data[i]),
                .offset   (offset[i]),
                .full     (full[i]),
                .ovf      (ovf[i])
            );
        end
    endgenerate

    always_comb begin
        err_val          = '0;
        err_val[NUM_BUF-1:0] = ovf;
        err_val[UDF_BIT] = udf;
        rd_mux           = '0;
        for (int k = 0; k < NUM_BUF; k++) begin
            if (bus.csr_addr == OFFSET_BASE + 8'(k)) rd_mux = DATA_W'(offset[k]);
            if (bus.csr_addr == CTRL_BASE + 8'(k)) rd_mux = DATA_W'({ovf[k], full[k]});
        end
        case (bus.csr_addr)
            FULL_ADDR:       rd_mux = DATA_W'(full);
            ERR_ADDR:        rd_mux = err_val;
            RDPTR_ADDR:      rd_mux = DATA_W'(bus.rd_buf_idx);
            TEST_ADDR_ADDR:  rd_mux = DATA_W'(bus.test_addr);
            TEST_WDATA_ADDR: rd_mux = bus.test_wr_data;
            TEST_CMD_ADDR:   rd_mux = DATA_W'(bus.test_wr_req);
            default:         ;
        endcase
    end

    // a new underflow in the same cycle as its write-1-to-clear keeps the bit set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.csr_rd_data  <= '0;
            bus.csr_rd_valid <= 1'b0;
            bus.rd_buf_idx   <= '0;
            udf              <= 1'b0;
            bus.test_addr    <= '0;
            bus.test_wr_data <= '0;
            bus.test_wr_req  <= 1'b0;
        end else begin
            bus.csr_rd_valid <= bus.csr_read;
            if (bus.csr_read) bus.csr_rd_data <= rd_mux;
            if (rel) bus.rd_buf_idx <= bus.rd_buf_idx == 4'(NUM_BUF - 1) ? 4'd0 : bus.rd_buf_idx + 4'd1;
            udf <= (bus.rd_buf_done && !bus.rd_buf_ready) || (udf && !(err_wr && bus.csr_wr_data[UDF_BIT]));
            if (bus.csr_write && bus.csr_addr == TEST_ADDR_ADDR) bus.test_addr <= bus.csr_wr_data[ADDR_W-1:0];
            if (bus.csr_write && bus.csr_addr == TEST_WDATA_ADDR) bus.test_wr_data <= bus.csr_wr_data;
            bus.test_wr_req <= bus.test_wr_req ? !bus.test_wr_ack
                                               : bus.csr_write && bus.csr_addr == TEST_CMD_ADDR && bus.csr_wr_data[0];
        end
    end
endmodule
